// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file with trap/mret/wfi sequencing; CSR_COUNTER_WR_EN makes the counters writable
module csr_file #(
    parameter logic [31:0] MTVEC_VAL    = 32'h0001_0000,
    parameter logic [1:0]  RESET_PC_MPP = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] csr_raddr,
    output logic [31:0] csr_rdata,
    input  logic        csr_we,
    input  logic [11:0] csr_waddr,
    input  logic [1:0]  csr_op,
    input  logic [31:0] csr_wsrc,
    input  logic        instr_retire,
    input  logic        stall,
    input  logic        ext_irq,
    input  logic [31:0] trap_pc,
    input  logic        mret,
    input  logic        wfi,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        halt
);
    typedef enum logic [1:0] {RUN, TRAP, WFI} state_t;
    state_t      state;
    logic        st_mie, st_mpie, meie, meip;
    logic [1:0]  st_mpp;
    logic [31:2] mepc;
    logic [63:0] cycle, instret, cyc_inc, ins_inc, cycle_nx, instret_nx;
    logic [31:0] wold, wval;
    logic        irq_take, trap_go, mret_go, wfi_go, w_en;
    logic        unused;

    function automatic logic [31:0] rd(input logic [11:0] a);
        case (a)
            12'h300: rd = {19'b0, st_mpp, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
            12'h304: rd = {20'b0, meie, 11'b0};
            12'h305: rd = MTVEC_VAL;
            12'h341: rd = {mepc, 2'b0};
            12'h344: rd = {20'b0, meip, 11'b0};
            12'hB00: rd = cycle[31:0];
            12'hB02: rd = cycle[63:32];
            12'hB80: rd = instret[31:0];
            12'hB82: rd = instret[63:32];
            default: rd = 32'h0;
        endcase
    endfunction

    assign csr_rdata = rd(csr_raddr);
    assign unused    = ^{trap_pc[1:0], wval[1:0]};

    always_comb begin
        wold        = rd(csr_waddr);
        wval        = csr_op == 2'b01 ? csr_wsrc : csr_op == 2'b10 ? wold | csr_wsrc :
                      csr_op == 2'b11 ? wold & ~csr_wsrc : wold;
        irq_take    = st_mie & meie & meip;
        trap_go     = state == RUN && irq_take;
        mret_go     = state == RUN && mret && !irq_take;
        wfi_go      = state == RUN && wfi && !irq_take && !mret;
        w_en        = csr_we && !stall && csr_op != 2'b00 && !trap_go && !mret_go && !wfi_go;
        cyc_inc     = cycle + 64'd1;
        ins_inc     = instret + 64'(instr_retire && !stall);
        redirect    = state == TRAP || mret_go;
        redirect_pc = state == TRAP ? MTVEC_VAL : mret_go ? {mepc, 2'b0} : 32'h0;
        halt        = state == WFI;
    end

`ifdef CSR_COUNTER_WR_EN
    logic wc_lo, wc_hi, wi_lo, wi_hi;
    // a low-half write holds the high half, swallowing that cycle's carry
    always_comb begin
        wc_lo      = w_en && csr_waddr == 12'hB00;
        wc_hi      = w_en && csr_waddr == 12'hB02;
        wi_lo      = w_en && csr_waddr == 12'hB80;
        wi_hi      = w_en && csr_waddr == 12'hB82;
        cycle_nx   = {wc_hi ? wval : wc_lo ? cycle[63:32] : cyc_inc[63:32],
                      wc_lo ? wval : cyc_inc[31:0]};
        instret_nx = {wi_hi ? wval : wi_lo ? instret[63:32] : ins_inc[63:32],
                      wi_lo ? wval : ins_inc[31:0]};
    end
`else
    always_comb begin
        cycle_nx   = cyc_inc;
        instret_nx = ins_inc;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= RUN;
            st_mie  <= 1'b0;
            st_mpie <= 1'b0;
            st_mpp  <= 2'b00;
            meie    <= 1'b0;
            meip    <= 1'b0;
            mepc    <= '0;
            cycle   <= '0;
            instret <= '0;
        end else begin
            cycle   <= cycle_nx;
            instret <= instret_nx;
            meip    <= ext_irq;
            state   <= trap_go ? TRAP : wfi_go ? WFI :
                       (state == WFI && !(meip && meie)) ? WFI : RUN;
            if (trap_go) begin
                mepc    <= trap_pc[31:2];
                st_mpie <= st_mie;
                st_mie  <= 1'b0;
                st_mpp  <= RESET_PC_MPP;
            end else if (mret_go) begin
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
            end else if (w_en) begin
                if (csr_waddr == 12'h300) begin
                    st_mpp  <= wval[12:11];
                    st_mpie <= wval[7];
                    st_mie  <= wval[3];
                end
                if (csr_waddr == 12'h304) meie <= wval[11];
                if (csr_waddr == 12'h341) mepc <= wval[31:2];
            end
        end
    end
endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed self-checking bench for csr_file
module tb_csr_file;
    logic        clk = 1'b0, rst = 1'b0;
    logic [11:0] csr_raddr = '0, csr_waddr = '0;
    logic [31:0] csr_rdata, csr_wsrc = '0, trap_pc = '0, redirect_pc;
    logic        csr_we = 1'b0, instr_retire = 1'b0, stall = 1'b0, ext_irq = 1'b0;
    logic        mret = 1'b0, wfi = 1'b0, redirect, halt;
    logic [1:0]  csr_op = 2'b00;
    logic [63:0] exp_cyc = '0;
    int          tests = 0, fails = 0;

    csr_file dut (
        .clk(clk), .rst(rst), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_op(csr_op), .csr_wsrc(csr_wsrc),
        .instr_retire(instr_retire), .stall(stall), .ext_irq(ext_irq), .trap_pc(trap_pc),
        .mret(mret), .wfi(wfi), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) exp_cyc <= rst ? exp_cyc + 64'd1 : 64'd0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_raddr = a;
        #1;
        chk(tag, csr_rdata, exp);
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [1:0] op, input logic [31:0] v);
        csr_we    = 1'b1;
        csr_waddr = a;
        csr_op    = op;
        csr_wsrc  = v;
        tick();
        csr_we    = 1'b0;
        csr_op    = 2'b00;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_redirect", 32'(redirect), 32'h0);
        chk("rst_redirect_pc", redirect_pc, 32'h0);
        chk("rst_halt", 32'(halt), 32'h0);
        chk_rd("rst_cycle", 12'hB00, 32'h0);
        rst = 1'b1;
        repeat (10) tick();
        chk_rd("cycle_10", 12'hB00, 32'd10);
        chk_rd("cycle_hi", 12'hB02, 32'h0);
        chk_rd("mtvec", 12'h305, 32'h0001_0000);
        chk_rd("mstatus_0", 12'h300, 32'h0);
        chk_rd("mie_0", 12'h304, 32'h0);
        chk_rd("mepc_0", 12'h341, 32'h0);
        csr_write(12'h300, 2'b01, 32'hFFFF_FFFF);
        chk_rd("mstatus_mask", 12'h300, 32'h0000_1888);
        csr_write(12'h300, 2'b11, 32'h8);
        chk_rd("mstatus_clr", 12'h300, 32'h0000_1880);
        csr_write(12'h300, 2'b10, 32'h0);
        chk_rd("mstatus_set0", 12'h300, 32'h0000_1880);
        csr_write(12'h341, 2'b01, 32'h1234_5677);
        chk_rd("mepc_mask", 12'h341, 32'h1234_5674);
        csr_write(12'h344, 2'b01, 32'hFFFF_FFFF);
        chk_rd("mip_ro", 12'h344, 32'h0);
        csr_write(12'h123, 2'b01, 32'hFFFF_FFFF);
        chk_rd("unmapped", 12'h123, 32'h0);
        csr_write(12'h304, 2'b01, 32'hFFFF_FFFF);
        chk_rd("mie_mask", 12'h304, 32'h0000_0800);
        instr_retire = 1'b1;
        repeat (3) tick();
        chk_rd("instret_3", 12'hB80, 32'd3);
        stall = 1'b1;
        csr_write(12'h341, 2'b01, 32'hFFFF_FFF0);
        tick();
        chk_rd("instret_stall", 12'hB80, 32'd3);
        chk_rd("mepc_stall", 12'h341, 32'h1234_5674);
        stall = 1'b0;
        instr_retire = 1'b0;
        csr_write(12'hB80, 2'b01, 32'h55);
`ifdef CSR_COUNTER_WR_EN
        chk_rd("instret_wr", 12'hB80, 32'h55);
`else
        chk_rd("instret_ro", 12'hB80, 32'd3);
        csr_write(12'hB00, 2'b01, 32'h0);
        chk_rd("cycle_ro", 12'hB00, exp_cyc[31:0]);
`endif
        csr_write(12'h300, 2'b10, 32'h8);
        chk_rd("mstatus_mie", 12'h300, 32'h0000_1888);
        trap_pc = 32'h0000_0400;
        ext_irq = 1'b1;
        tick();
        csr_we = 1'b1; csr_waddr = 12'h341; csr_op = 2'b01; csr_wsrc = 32'hDEAD_0000;
        chk("trap_pre_redirect", 32'(redirect), 32'h0);
        tick();
        csr_we = 1'b0; csr_op = 2'b00;
        chk("trap_redirect", 32'(redirect), 32'h1);
        chk("trap_redirect_pc", redirect_pc, 32'h0001_0000);
        chk_rd("trap_mepc", 12'h341, 32'h0000_0400);
        chk_rd("trap_mstatus", 12'h300, 32'h0000_1880);
        tick();
        chk("trap_pulse_end", 32'(redirect), 32'h0);
        ext_irq = 1'b0;
        mret = 1'b1;
        #1;
        chk("mret_redirect", 32'(redirect), 32'h1);
        chk("mret_redirect_pc", redirect_pc, 32'h0000_0400);
        tick();
        mret = 1'b0;
        chk_rd("mret_mstatus", 12'h300, 32'h0000_1888);
        chk("mret_pulse_end", 32'(redirect), 32'h0);
        csr_write(12'h300, 2'b11, 32'h8);
        wfi = 1'b1;
        #1;
        chk("wfi_pre_halt", 32'(halt), 32'h0);
        tick();
        wfi = 1'b0;
        chk("wfi_halt", 32'(halt), 32'h1);
        tick();
        chk("wfi_hold", 32'(halt), 32'h1);
        ext_irq = 1'b1;
        tick();
        chk("wfi_halt_1", 32'(halt), 32'h1);
        tick();
        chk("wfi_wake", 32'(halt), 32'h0);
        chk("wfi_no_redirect", 32'(redirect), 32'h0);
        ext_irq = 1'b0;
        tick();
        chk("wfi_no_trap", 32'(redirect), 32'h0);
        chk_rd("wfi_mstatus", 12'h300, 32'h0000_1880);
        wfi = 1'b1;
        tick();
        wfi = 1'b0;
        chk("wfi2_halt", 32'(halt), 32'h1);
        rst = 1'b0;
        tick();
        chk("rst_wfi_halt", 32'(halt), 32'h0);
        chk_rd("rst_mie", 12'h304, 32'h0);
        chk_rd("rst_mepc", 12'h341, 32'h0);
        chk_rd("rst_mstatus", 12'h300, 32'h0);
        chk_rd("rst_cycle2", 12'hB00, 32'h0);
        rst = 1'b1;
        tick();
        chk_rd("cycle_after_rst", 12'hB00, 32'd1);
`ifdef CSR_COUNTER_WR_EN
        csr_write(12'hB02, 2'b01, 32'hFFFF_FFFF);
        csr_write(12'hB00, 2'b01, 32'hFFFF_FFFF);
        chk_rd("cycle_wr_lo", 12'hB00, 32'hFFFF_FFFF);
        chk_rd("cycle_wr_hi", 12'hB02, 32'hFFFF_FFFF);
        tick();
        chk_rd("cycle_wrap_lo", 12'hB00, 32'h0);
        chk_rd("cycle_wrap_hi", 12'hB02, 32'h0);
`else
        csr_write(12'hB00, 2'b01, 32'hFFFF_FFFF);
        chk_rd("cycle_ro2", 12'hB00, exp_cyc[31:0]);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
Machine-mode CSR register file for the 5-stage CPU. It is the write/update end of the CSR path: it holds mstatus, mie, mtvec, mepc, mip and the 64-bit cycle/instret counters, and applies CSRRW/CSRRS/CSRRC writebacks. It also sequences external-interrupt trap entry, mret and wfi, and drives the PC-redirect outputs. The WB-stage forwarding mux consumes its read data using the same field masks.

Parameters:
MTVEC_VAL, 32'h0001_0000, hardwired trap vector; mtvec is read-only.
RESET_PC_MPP, 2'b11, value loaded into mstatus.MPP on trap entry.

Ports:
clk  in  1  core clock
rst  in  1  reset; synchronous, active-low
csr_raddr  in  12  CSR read address (ID stage)
csr_rdata  out  32  masked read data, combinational
csr_we  in  1  CSR instruction writeback valid (WB stage)
csr_waddr  in  12  CSR write address
csr_op  in  2  00 none, 01 write, 10 set, 11 clear
csr_wsrc  in  32  rs1 value or zero-extended uimm
instr_retire  in  1  one instruction retired this cycle
stall  in  1  pipeline stall; blocks csr_we and instr_retire
ext_irq  in  1  level external interrupt, sampled into mip.MEIP
trap_pc  in  32  PC to save in mepc on trap entry
mret  in  1  mret in WB
wfi  in  1  wfi in WB
redirect  out  1  one-cycle PC redirect pulse
redirect_pc  out  32  target PC, valid while redirect=1
halt  out  1  core frozen in WFI state

Behaviour:
- Field map and write masks. Only these bits are stored; all other bits read 0.
  - 0x300 mstatus: MPP[12:11], MPIE[7], MIE[3].
  - 0x304 mie: MEIE[11].
  - 0x305 mtvec: reads MTVEC_VAL.
  - 0x341 mepc: [31:2] stored, [1:0] read 0.
  - 0x344 mip: MEIP[11], read-only; CSR writes are ignored.
  - 0xB00 cycle[31:0], 0xB02 cycle[63:32], 0xB80 instret[31:0], 0xB82 instret[63:32].
  - Any unmapped address reads 32'h0; writes to it are ignored.
- Write value: new = op01 ? wsrc : op10 ? old|wsrc : op11 ? old&~wsrc : old.
  - Committed at the clk edge when csr_we=1, stall=0 and op!=00.
  - A set or clear with wsrc=0 leaves the register unchanged.
- Counters:
  - cycle increments every clock while rst=1, including stall and WFI.
  - instret increments when instr_retire=1 and stall=0.
  - Both wrap from 2^64-1 to 0.
  - Counters are read-only unless CSR_COUNTER_WR_EN is defined.
- mip.MEIP is registered from ext_irq each cycle, giving 1 cycle of sampling latency.
- irq_take = mstatus.MIE & mie.MEIE & mip.MEIP.
- FSM states: RUN, TRAP, WFI.
  - RUN to TRAP when irq_take=1.
    - On the transition edge: mepc<=trap_pc, MPIE<=MIE, MIE<=0, MPP<=RESET_PC_MPP.
    - Any same-cycle csr_we, mret or wfi is dropped; the trap wins.
  - TRAP (exactly 1 cycle): redirect=1, redirect_pc=MTVEC_VAL. Next state is RUN.
  - RUN with mret=1 and irq_take=0 stays in RUN.
    - On the edge: MIE<=MPIE, MPIE<=1.
    - redirect=1 and redirect_pc=mepc are asserted in the same cycle (combinational).
    - A same-cycle csr_we is dropped.
  - RUN with wfi=1 and irq_take=0 goes to WFI. halt=1 from the next cycle.
  - WFI to RUN when mip.MEIP & mie.MEIE, regardless of MIE.
    - If MIE=1, the next cycle also evaluates irq_take and enters TRAP.
  - Priority in RUN: trap > mret > wfi > csr write.
- Read path: csr_rdata is purely combinational from csr_raddr and current state.
  - No internal write-to-read bypass; forwarding is handled outside this block.
- Reset (rst=0 at a clk edge):
  - All CSRs 0, mip 0, counters 0, state RUN.
  - redirect=0, redirect_pc=0, halt=0.
  - Reset has priority over every other event, including mid-TRAP and WFI.

Optional Feature:
CSR_COUNTER_WR_EN
- Defined: CSR writes to 0xB00/0xB02/0xB80/0xB82 update the addressed 32-bit half.
  - The write overrides that cycle's increment for the written half.
  - The other half still carries or increments as normal: a low-half write suppresses the carry into the high half that cycle.
- Undefined: counter writes are ignored and counters are read-only.

Test Plan:
- Reset, then 10 cycles: cycle reads 10 at 0xB00 (±read timing). mtvec reads 32'h0001_0000; mstatus, mie, mepc read 0.
- Masks:
  - csr_op=01 to 0x300 with wsrc=32'hFFFF_FFFF → mstatus reads 32'h0000_1888.
  - csr_op=11 with wsrc=32'h8 → mstatus reads 32'h0000_1880.
  - csr_op=01 to 0x341 with 32'h1234_5677 → mepc reads 32'h1234_5674.
- Trap entry:
  - Setup: MIE=1, MEEIE=1 written via CSR, trap_pc=32'h0000_0400, raise ext_irq.
  - Response: redirect pulses 1 cycle with redirect_pc=32'h0001_0000; mepc=0x400; MIE=0, MPIE=1, MPP=2'b11.
  - A csr_we issued in the entry cycle is lost.
- mret after the trap: redirect=1 with redirect_pc=32'h0000_0400 in the same cycle; next cycle MIE=1, MPIE=1.
- WFI with MIE=0 and MEIE=1: halt=1 until ext_irq rises; halt drops 2 cycles after ext_irq rises; no redirect.
- Counter wrap:
  - Without CSR_COUNTER_WR_EN: a write to 0xB00 is ignored.
  - With it: write 0xB00=32'hFFFF_FFFF and 0xB02=32'hFFFF_FFFF; 1 cycle later both halves read 0.
  - instret holds while stall=1 and instr_retire=1.
